reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Integer register file for the RISC-V core.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- Sits between decode (supplies the register indices) and writeback (supplies the result and write enable).

Parameters:
- REG_DATA_WIDTH_POW, default 6: log2 of register width. Local REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW (64 bits by default).
- REG_MEM_DEPTH_POW, default 5: log2 of register count. Local REG_MEM_DEPTH = 1 << REG_MEM_DEPTH_POW (32 registers by default).

Ports:
- clk_in  input  1  system clock; all writes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rs1_in  input  REG_MEM_DEPTH_POW  read port 1 register index.
- rs2_in  input  REG_MEM_DEPTH_POW  read port 2 register index.
- rd_in  input  REG_MEM_DEPTH_POW  write register index.
- data_write  input  REG_DATA_WIDTH  write data.
- write_en  input  1  write enable; active high.
- reg_data1_out  output  REG_DATA_WIDTH  contents of register rs1_in.
- reg_data2_out  output  REG_DATA_WIDTH  contents of register rs2_in.

Behaviour:
- Interface: one clock (clk_in); reset rst_n_in is asynchronous and active-low.
- Storage: REG_MEM_DEPTH entries of REG_DATA_WIDTH bits each.
- Reset:
  - rst_n_in low immediately clears every entry to 0, independent of clk_in.
  - While reset is held, both outputs read 0 for any index.
  - Writes are ignored while rst_n_in is low.
  - Reset asserted mid-operation discards all contents.
- Write:
  - On posedge clk_in with rst_n_in high, write_en=1 and rd_in!=0, the entry rd_in takes data_write.
  - write_en=0: no entry changes.
  - rd_in=0: write is silently dropped.
- Read:
  - Purely combinational, zero latency: reg_data1_out = entry[rs1_in] and reg_data2_out = entry[rs2_in].
  - Index 0 always returns 0 on both ports.
- Read-after-write:
  - A value written at posedge N is visible on any read port addressing rd from just after posedge N onward.
  - It is therefore stable when sampled at posedge N+1.
- Same-cycle read/write to the same index:
  - Before the edge, the read returns the old value; there is no internal write-through bypass.
  - Forwarding is handled by the pipeline.
- Both read ports may address the same register simultaneously; both return identical data.
- All index values 0..REG_MEM_DEPTH-1 are legal, so no out-of-range handling is required.
- Only the addressed entry changes on a write; all other entries hold their values.

Test Plan:
- Reset: drive rst_n_in=0 mid-clock, then release; read all 32 indices on both ports -> every read returns 0.
- Write/read-back:
  - write_en=1, rd_in=5, data_write=0xDEADBEEF_CAFEF00D at posedge N.
  - Set rs1_in=5 and rs2_in=5 -> both outputs show 0xDEADBEEF_CAFEF00D at posedge N+1.
  - Other indices are still 0.
- x0 immutability: write_en=1, rd_in=0, data_write=all ones -> reads of index 0 on both ports remain 0.
- Write disabled: preload reg 7 = 0x1234; then write_en=0, rd_in=7, data_write=0xFFFF for several cycles -> reg 7 still reads 0x1234.
- Same-cycle collision:
  - Preload reg 3 = 0xAAAA; rs1_in=3; write 0x5555 to reg 3.
  - Before posedge, reg_data1_out=0xAAAA; after posedge, 0x5555.
- Full sweep:
  - Write value (i*0x0101_0101_0101_0101) to regs 1..31 on consecutive cycles.
  - Read back with rs1_in=i and rs2_in=31-i -> each port returns its expected value; index 0 returns 0.

Source files
------------

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one synchronous write port.
// Entry 0 has no storage and always reads as zero.
module reg_file #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        rs1_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        rs2_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        rd_in,
    input  logic [(1 << REG_DATA_WIDTH_POW)-1:0] data_write,
    input  logic                                write_en,
    output logic [(1 << REG_DATA_WIDTH_POW)-1:0] reg_data1_out,
    output logic [(1 << REG_DATA_WIDTH_POW)-1:0] reg_data2_out
);

    localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
    localparam int REG_MEM_DEPTH  = 1 << REG_MEM_DEPTH_POW;

    logic [REG_DATA_WIDTH-1:0] entry_value [REG_MEM_DEPTH];

    // Flops rather than RAM: the whole file must clear asynchronously on reset.
    genvar gi;
    generate
        for (gi = 0; gi < REG_MEM_DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign entry_value[gi] = '0;
            end else begin : g_store
                logic [REG_DATA_WIDTH-1:0] value_reg;
                logic                      hit;

                assign hit = write_en && (rd_in == REG_MEM_DEPTH_POW'(gi));

                always_ff @(posedge clk_in or negedge rst_n_in) begin
                    if (!rst_n_in) begin
                        value_reg <= '0;
                    end else if (hit) begin
                        value_reg <= data_write;
                    end
                end

                assign entry_value[gi] = value_reg;
            end
        end
    endgenerate

    // No write-through bypass: forwarding is the pipeline's job.
    assign reg_data1_out = entry_value[rs1_in];
    assign reg_data2_out = entry_value[rs2_in];

endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file against an array-based reference model.
module tb_reg_file;

    logic        clk_in;
    logic        rst_n_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [4:0]  rd_in;
    logic [63:0] data_write;
    logic        write_en;
    logic [63:0] reg_data1_out;
    logic [63:0] reg_data2_out;

    int checks_total  = 0;
    int checks_passed = 0;
    bit check_en      = 0;

    logic [63:0] model [32];

    reg_file #(
        .REG_DATA_WIDTH_POW(6),
        .REG_MEM_DEPTH_POW (5)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rs1_in       (rs1_in),
        .rs2_in       (rs2_in),
        .rd_in        (rd_in),
        .data_write   (data_write),
        .write_en     (write_en),
        .reg_data1_out(reg_data1_out),
        .reg_data2_out(reg_data2_out)
    );

    initial clk_in = 0;
    always #5 clk_in = ~clk_in;

    // Reference: reset wipes everything, an enabled write to a nonzero index stores data.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (write_en && rd_in != 0) begin
            model[rd_in] = data_write;
        end
    end

    function automatic logic [63:0] expect_read(input logic [4:0] idx);
        if (!rst_n_in || idx == 0) return '0;
        return model[idx];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else begin
            checks_passed++;
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Per-cycle comparison against the model, silent unless something differs.
    always @(negedge clk_in) begin
        if (check_en) begin
            checks_total += 2;
            if (reg_data1_out !== expect_read(rs1_in))
                $display("FAIL cycle_port1 rs1=%0d: got %h, expected %h (t=%0t)",
                         rs1_in, reg_data1_out, expect_read(rs1_in), $time);
            else
                checks_passed++;
            if (reg_data2_out !== expect_read(rs2_in))
                $display("FAIL cycle_port2 rs2=%0d: got %h, expected %h (t=%0t)",
                         rs2_in, reg_data2_out, expect_read(rs2_in), $time);
            else
                checks_passed++;
        end
    end

    task automatic do_write(input logic [4:0] rd, input logic [63:0] d, input logic en);
        write_en   = en;
        rd_in      = rd;
        data_write = d;
        @(posedge clk_in);
        #1;
        write_en = 0;
    endtask

    task automatic mid_cycle_reset();
        @(posedge clk_in);
        #3 rst_n_in = 0;
        #1;
    endtask

    logic [63:0] sweep_k;

    initial begin
        rst_n_in   = 0;
        rs1_in     = 5;
        rs2_in     = 0;
        rd_in      = 0;
        data_write = '0;
        write_en   = 0;
        sweep_k    = 64'h0101_0101_0101_0101;

        repeat (3) @(posedge clk_in);
        #1;
        check("reset_port1", reg_data1_out, 64'h0);
        check("reset_port2", reg_data2_out, 64'h0);
        rst_n_in = 1;
        check_en = 1;

        // Write then read back on both ports.
        do_write(5'd5, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        rs1_in = 5;
        rs2_in = 5;
        @(negedge clk_in);
        check("wr5_port1", reg_data1_out, 64'hDEAD_BEEF_CAFE_F00D);
        check("wr5_port2", reg_data2_out, 64'hDEAD_BEEF_CAFE_F00D);
        @(posedge clk_in); #1;
        rs1_in = 6;
        rs2_in = 4;
        #1;
        check("other_port1", reg_data1_out, 64'h0);
        check("other_port2", reg_data2_out, 64'h0);

        // x0 immutability.
        do_write(5'd0, '1, 1'b1);
        rs1_in = 0;
        rs2_in = 0;
        #1;
        check("x0_port1", reg_data1_out, 64'h0);
        check("x0_port2", reg_data2_out, 64'h0);

        // Write disabled.
        do_write(5'd7, 64'h1234, 1'b1);
        repeat (4) do_write(5'd7, 64'hFFFF, 1'b0);
        rs1_in = 7;
        #1;
        check("wr_disabled", reg_data1_out, 64'h1234);

        // Same-cycle read/write collision: old value before the edge, new after.
        do_write(5'd3, 64'hAAAA, 1'b1);
        rs1_in     = 3;
        write_en   = 1;
        rd_in      = 3;
        data_write = 64'h5555;
        @(negedge clk_in);
        check("collide_before", reg_data1_out, 64'hAAAA);
        @(posedge clk_in); #1;
        write_en = 0;
        check("collide_after", reg_data1_out, 64'h5555);

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 400; c++) begin
            rd_in      = 5'($urandom_range(0, 31));
            write_en   = ($urandom_range(0, 3) != 0);
            data_write = {$urandom, $urandom};
            rs1_in     = ($urandom_range(0, 3) == 0) ? rd_in : 5'($urandom_range(0, 31));
            rs2_in     = ($urandom_range(0, 7) == 0) ? rs1_in : 5'($urandom_range(0, 31));
            @(posedge clk_in); #1;
            if (c == 200) begin
                mid_cycle_reset();
                @(posedge clk_in); #1;
                rst_n_in = 1;
            end
        end
        write_en = 0;

        // Reset in the middle of operation discards everything.
        do_write(5'd9, 64'h0BAD_F00D_0000_0009, 1'b1);
        rs1_in = 9;
        mid_cycle_reset();
        check("async_reset_clear", reg_data1_out, 64'h0);
        @(posedge clk_in); #1;
        rst_n_in = 1;
        for (int i = 0; i < 32; i++) begin
            rs1_in = 5'(i);
            rs2_in = 5'(31 - i);
            #1;
            if (reg_data1_out !== 64'h0 || reg_data2_out !== 64'h0)
                check($sformatf("post_reset_idx%0d", i),
                      reg_data1_out | reg_data2_out, 64'h0);
            else
                check($sformatf("post_reset_idx%0d", i), reg_data1_out, 64'h0);
            @(posedge clk_in); #1;
        end

        // Full sweep.
        for (int i = 1; i < 32; i++) do_write(5'(i), 64'(i) * sweep_k, 1'b1);
        for (int i = 0; i < 32; i++) begin
            rs1_in = 5'(i);
            rs2_in = 5'(31 - i);
            #1;
            check($sformatf("sweep_p1_idx%0d", i), reg_data1_out, 64'(i) * sweep_k);
            check($sformatf("sweep_p2_idx%0d", 31 - i), reg_data2_out, 64'(31 - i) * sweep_k);
            @(posedge clk_in); #1;
        end

        check_en = 0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
